dm_wb_cache: RTL and testbench

//   Parametrised direct-mapped, write-back, write-allocate cache between the CPU's word memory port
//   (mem_read/mem_write/mem_byte_enable/mem_address/mem_wdata -> mem_rdata/mem_resp) and a

---
 rtl/dm_wb_cache.sv | 133 +++++++++++++
 tb/tb_dm_wb_cache.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/dm_wb_cache.sv
// Direct-mapped, write-back, write-allocate cache between a CPU word port and line-wide memory.
// Hits complete combinationally in the request cycle; misses run WRITEBACK (if dirty) then FILL.
module dm_wb_cache #(
  parameter int S_INDEX  = 3,
  parameter int S_OFFSET = 5,
  parameter int LINE_W   = 8 * (2 ** S_OFFSET),
  parameter int TAG_W    = 32 - S_INDEX - S_OFFSET
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [3:0]        mem_byte_enable,
  input  logic [31:0]       mem_address,
  input  logic [31:0]       mem_wdata,
  output logic [31:0]       mem_rdata,
  output logic              mem_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [31:0]       pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  // state     | meaning
  // IDLE      | serve hits, detect misses
  // WRITEBACK | write dirty victim line to memory
  // FILL      | read requested line from memory
  typedef enum logic [1:0] {IDLE, WRITEBACK, FILL} state_t;

  localparam int SETS  = 2 ** S_INDEX;
  localparam int WORDS = 2 ** (S_OFFSET - 2);

  state_t state, state_next;

  logic [LINE_W-1:0] data_arr [SETS];
  logic [TAG_W-1:0]  tag_arr  [SETS];
  logic [SETS-1:0]   valid, dirty;

  // Line address of the miss being serviced; the CPU may drop or change its request mid-miss.
  logic [31-S_OFFSET:0] miss_line;

  logic [TAG_W-1:0]   req_tag, miss_tag;
  logic [S_INDEX-1:0] req_idx, miss_idx;
  logic [31:0]        word_idx;
  logic               req, hit, wr_hit;
  logic               wb_done, fill_done;
  logic [LINE_W-1:0]  merged;
  logic               unused_addr_lsb;

  assign req_tag   = mem_address[31 -: TAG_W];
  assign req_idx   = mem_address[S_OFFSET +: S_INDEX];
  assign word_idx  = (mem_address >> 2) & 32'(WORDS - 1);
  assign miss_tag  = miss_line[31-S_OFFSET -: TAG_W];
  assign miss_idx  = miss_line[S_INDEX-1:0];
  assign unused_addr_lsb = ^mem_address[1:0];

  assign req       = mem_read | mem_write;
  assign hit       = req && valid[req_idx] && (tag_arr[req_idx] == req_tag);
  assign wr_hit    = (state == IDLE) && hit && mem_write && (|mem_byte_enable);
  assign wb_done   = (state == WRITEBACK) && pmem_resp;
  assign fill_done = (state == FILL) && pmem_resp;

  always_comb begin
    merged = data_arr[req_idx];
    for (int b = 0; b < 4; b++) begin
      if (mem_byte_enable[b]) merged[word_idx*32 + b*8 +: 8] = mem_wdata[b*8 +: 8];
    end
  end

  always_comb begin
    state_next   = state;
    mem_resp     = 1'b0;
    mem_rdata    = '0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    case (state)
      IDLE: begin
        if (hit) begin
          mem_resp = 1'b1;
          if (!mem_write) mem_rdata = data_arr[req_idx][word_idx*32 +: 32];
        end else if (req) begin
          state_next = (valid[req_idx] && dirty[req_idx]) ? WRITEBACK : FILL;
        end
      end
      WRITEBACK: begin
        pmem_write   = 1'b1;
        pmem_address = {tag_arr[miss_idx], miss_idx, {S_OFFSET{1'b0}}};
        pmem_wdata   = data_arr[miss_idx];
        if (pmem_resp) state_next = FILL;
      end
      FILL: begin
        pmem_read    = 1'b1;
        pmem_address = {miss_line, {S_OFFSET{1'b0}}};
        if (pmem_resp) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      valid     <= '0;
      dirty     <= '0;
      miss_line <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && req && !hit) miss_line <= mem_address[31:S_OFFSET];
      if (wr_hit) dirty[req_idx] <= 1'b1;
      if (wb_done) dirty[miss_idx] <= 1'b0;
      if (fill_done) begin
        valid[miss_idx] <= 1'b1;
        dirty[miss_idx] <= 1'b0;
      end
    end
  end

  // Data and tag storage carry no reset; valid bits gate their use.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (wr_hit) data_arr[req_idx] <= merged;
      if (fill_done) begin
        data_arr[miss_idx] <= pmem_rdata;
        tag_arr[miss_idx]  <= miss_tag;
      end
    end
  end

endmodule

// File: tb/tb_dm_wb_cache.sv
// Directed self-checking bench for dm_wb_cache with a 3-cycle line memory model.
`timescale 1ns/1ps
module tb_dm_wb_cache;
  localparam int LW = 256;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          mem_read = 1'b0, mem_write = 1'b0;
  logic [3:0]    mem_byte_enable = 4'b0;
  logic [31:0]   mem_address = '0, mem_wdata = '0;
  logic [31:0]   mem_rdata;
  logic          mem_resp;
  logic          pmem_read, pmem_write;
  logic [31:0]   pmem_address;
  logic [LW-1:0] pmem_wdata;
  logic [LW-1:0] pmem_rdata = '0;
  logic          pmem_resp = 1'b0;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  dm_wb_cache #(.S_INDEX(3), .S_OFFSET(5)) dut (
    .clk(clk), .rst(rst),
    .mem_read(mem_read), .mem_write(mem_write), .mem_byte_enable(mem_byte_enable),
    .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  // Line memory: answers on the third cycle a request is seen.
  logic [LW-1:0] pmem [logic [31:0]];
  int            n_rd = 0, n_wr = 0;
  logic [31:0]   last_rd_addr = '0, last_wr_addr = '0;
  logic [LW-1:0] last_wr_data = '0;
  bit            busy = 0, both_high = 0, addr_unstable = 0;
  int            wcnt = 0;
  logic [31:0]   start_addr = '0;

  always @(negedge clk) begin
    pmem_resp = 1'b0;
    if (pmem_read && pmem_write) both_high = 1;
    if (pmem_read || pmem_write) begin
      if (!busy) begin
        busy = 1; wcnt = 0; start_addr = pmem_address;
      end else if (pmem_address !== start_addr) begin
        addr_unstable = 1;
      end
      wcnt++;
      if (wcnt == 3) begin
        pmem_resp = 1'b1;
        busy = 0;
        if (pmem_write) begin
          pmem[pmem_address] = pmem_wdata;
          n_wr++; last_wr_addr = pmem_address; last_wr_data = pmem_wdata;
        end else begin
          pmem_rdata = pmem.exists(pmem_address) ? pmem[pmem_address] : '0;
          n_rd++; last_rd_addr = pmem_address;
        end
      end
    end else begin
      busy = 0;
    end
  end

  // Called just after a rising edge; returns just after the edge that completes the access.
  task automatic cpu_access(input logic rd, input logic wr, input logic [31:0] a,
                            input logic [3:0] be, input logic [31:0] wd,
                            output logic [31:0] rdata, output int cyc);
    mem_read = rd; mem_write = wr; mem_address = a; mem_byte_enable = be; mem_wdata = wd;
    cyc = 0; rdata = '0;
    while (cyc < 50) begin
      @(negedge clk);
      cyc++;
      if (mem_resp) begin
        rdata = mem_rdata;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    mem_read = 0; mem_write = 0; mem_byte_enable = '0;
  endtask

  logic [LW-1:0] line40, line140, line240;
  logic [31:0]   rdata;
  int            cyc;

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    total++; if (mem_resp !== 1'b0) $display("FAIL reset_mem_resp: got %b expected 0", mem_resp); else passed++;
    total++; if ({pmem_read, pmem_write} !== 2'b00) $display("FAIL reset_pmem_req: got %b expected 00", {pmem_read, pmem_write}); else passed++;
    total++; if (mem_rdata !== 32'h0 || pmem_address !== 32'h0 || pmem_wdata !== '0)
      $display("FAIL reset_data: rdata %h paddr %h expected zeros", mem_rdata, pmem_address); else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_read_miss_hit();
    cpu_access(1, 0, 32'h40, 4'h0, 32'h0, rdata, cyc);
    total++; if (cyc !== 5) $display("FAIL t1_miss_latency: got %0d expected 5", cyc); else passed++;
    total++; if (rdata !== 32'hDEADBEEF) $display("FAIL t1_miss_rdata: got %h expected deadbeef", rdata); else passed++;
    total++; if (last_rd_addr !== 32'h40 || n_rd !== 1) $display("FAIL t1_fill_addr: got %h n=%0d expected 40 n=1", last_rd_addr, n_rd); else passed++;
    cpu_access(1, 0, 32'h40, 4'h0, 32'h0, rdata, cyc);
    total++; if (cyc !== 1) $display("FAIL t1_hit_latency: got %0d expected 1", cyc); else passed++;
    total++; if (rdata !== 32'hDEADBEEF || n_rd !== 1) $display("FAIL t1_hit_rdata: got %h n=%0d expected deadbeef n=1", rdata, n_rd); else passed++;
  endtask

  task automatic test_write_hit();
    cpu_access(0, 1, 32'h44, 4'b0011, 32'h12345678, rdata, cyc);
    total++; if (cyc !== 1) $display("FAIL t2_write_latency: got %0d expected 1", cyc); else passed++;
    cpu_access(1, 0, 32'h44, 4'h0, 32'h0, rdata, cyc);
    total++; if (rdata !== 32'hAAAA5678 || cyc !== 1) $display("FAIL t2_merge_read: got %h cyc %0d expected aaaa5678 cyc 1", rdata, cyc); else passed++;
    total++; if (n_wr !== 0) $display("FAIL t2_no_writeback: got %0d expected 0", n_wr); else passed++;
  endtask

  task automatic test_dirty_miss();
    logic [LW-1:0] exp;
    exp = line40;
    exp[63:32] = 32'hAAAA5678;
    cpu_access(1, 0, 32'h140, 4'h0, 32'h0, rdata, cyc);
    total++; if (cyc !== 8) $display("FAIL t3_latency: got %0d expected 8", cyc); else passed++;
    total++; if (n_wr !== 1 || last_wr_addr !== 32'h40) $display("FAIL t3_wb_addr: got %h n=%0d expected 40 n=1", last_wr_addr, n_wr); else passed++;
    total++; if (last_wr_data !== exp) $display("FAIL t3_wb_data: got %h expected %h", last_wr_data[63:0], exp[63:0]); else passed++;
    total++; if (last_rd_addr !== 32'h140 || rdata !== 32'h01400140) $display("FAIL t3_fill: addr %h rdata %h expected 140 01400140", last_rd_addr, rdata); else passed++;
  endtask

  task automatic test_clean_miss();
    cpu_access(1, 0, 32'h40, 4'h0, 32'h0, rdata, cyc);
    total++; if (cyc !== 5 || n_wr !== 1 || rdata !== 32'hDEADBEEF) $display("FAIL t4_clean_40: cyc %0d nwr %0d rdata %h expected 5 1 deadbeef", cyc, n_wr, rdata); else passed++;
    cpu_access(1, 0, 32'h140, 4'h0, 32'h0, rdata, cyc);
    total++; if (cyc !== 5 || n_wr !== 1 || last_rd_addr !== 32'h140) $display("FAIL t4_clean_140: cyc %0d nwr %0d addr %h expected 5 1 140", cyc, n_wr, last_rd_addr); else passed++;
  endtask

  task automatic test_reset_mid_fill();
    int rd_before;
    rd_before = n_rd;
    mem_read = 1; mem_address = 32'h40;
    @(negedge clk);
    total++; if (mem_resp !== 1'b0) $display("FAIL t5_miss_resp: got %b expected 0", mem_resp); else passed++;
    @(posedge clk); #1;
    rst = 1'b1; mem_read = 0;
    @(negedge clk);
    total++; if (pmem_read !== 1'b1 || pmem_address !== 32'h40) $display("FAIL t5_fill_req: rd %b addr %h expected 1 40", pmem_read, pmem_address); else passed++;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    total++; if (pmem_read !== 1'b0 || pmem_write !== 1'b0) $display("FAIL t5_abandon: rd %b wr %b expected 0 0", pmem_read, pmem_write); else passed++;
    @(posedge clk); #1;
    cpu_access(1, 0, 32'h140, 4'h0, 32'h0, rdata, cyc);
    total++; if (cyc !== 5 || n_rd !== rd_before + 1) $display("FAIL t5_invalidated: cyc %0d nrd %0d expected 5 %0d", cyc, n_rd, rd_before + 1); else passed++;
    cpu_access(1, 0, 32'h40, 4'h0, 32'h0, rdata, cyc);
    total++; if (cyc !== 5 || rdata !== 32'hDEADBEEF) $display("FAIL t5_remiss: cyc %0d rdata %h expected 5 deadbeef", cyc, rdata); else passed++;
  endtask

  task automatic test_read_write_both();
    cpu_access(1, 1, 32'h48, 4'b1111, 32'hCAFEF00D, rdata, cyc);
    total++; if (cyc !== 1) $display("FAIL t6_rw_latency: got %0d expected 1", cyc); else passed++;
    cpu_access(1, 0, 32'h48, 4'h0, 32'h0, rdata, cyc);
    total++; if (rdata !== 32'hCAFEF00D) $display("FAIL t6_rw_read: got %h expected cafef00d", rdata); else passed++;
    cpu_access(0, 1, 32'h48, 4'b0000, 32'hFFFFFFFF, rdata, cyc);
    cpu_access(1, 0, 32'h48, 4'h0, 32'h0, rdata, cyc);
    total++; if (rdata !== 32'hCAFEF00D || cyc !== 1) $display("FAIL t6_be_zero: got %h cyc %0d expected cafef00d 1", rdata, cyc); else passed++;
  endtask

  task automatic test_dropped_request();
    int rd_before, wr_before, resp_seen;
    rd_before = n_rd; wr_before = n_wr; resp_seen = 0;
    mem_read = 1; mem_address = 32'h240;
    @(negedge clk);
    if (mem_resp) resp_seen++;
    @(posedge clk); #1;
    mem_read = 0; mem_address = 32'h0;
    repeat (20) begin
      @(negedge clk);
      if (mem_resp) resp_seen++;
    end
    @(posedge clk); #1;
    total++; if (resp_seen !== 0) $display("FAIL drop_no_resp: got %0d expected 0", resp_seen); else passed++;
    total++; if (n_wr !== wr_before + 1 || last_wr_addr !== 32'h40 || last_wr_data[95:64] !== 32'hCAFEF00D)
      $display("FAIL drop_wb: n %0d addr %h w2 %h expected %0d 40 cafef00d", n_wr, last_wr_addr, last_wr_data[95:64], wr_before + 1); else passed++;
    total++; if (n_rd !== rd_before + 1 || last_rd_addr !== 32'h240) $display("FAIL drop_fill: n %0d addr %h expected %0d 240", n_rd, last_rd_addr, rd_before + 1); else passed++;
    cpu_access(1, 0, 32'h240, 4'h0, 32'h0, rdata, cyc);
    total++; if (cyc !== 1 || rdata !== 32'h02400240) $display("FAIL drop_then_hit: cyc %0d rdata %h expected 1 02400240", cyc, rdata); else passed++;
  endtask

  task automatic test_protocol();
    total++; if (both_high !== 1'b0) $display("FAIL proto_both_high: got %b expected 0", both_high); else passed++;
    total++; if (addr_unstable !== 1'b0) $display("FAIL proto_addr_stable: got %b expected 0", addr_unstable); else passed++;
  endtask

  initial begin
    line40 = '0;  line40[31:0] = 32'hDEADBEEF; line40[63:32] = 32'hAAAABBBB;
    line140 = '0; line140[31:0] = 32'h01400140;
    line240 = '0; line240[31:0] = 32'h02400240;
    pmem[32'h40] = line40;
    pmem[32'h140] = line140;
    pmem[32'h240] = line240;
    test_reset();
    test_read_miss_hit();
    test_write_hit();
    test_dirty_miss();
    test_clean_miss();
    test_reset_mid_fill();
    test_read_write_both();
    test_dropped_request();
    test_protocol();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
